// File: rtl/dmem_mmio_pkg.sv
// Shared constants for the data-memory stage: MMIO register offsets and bit positions.
package dmem_mmio_pkg;

  localparam logic [15:0] MMIO_HI_DEFAULT = 16'hFFFF;

  localparam logic [7:0] OFS_CTRL  = 8'h00;
  localparam logic [7:0] OFS_LOAD  = 8'h04;
  localparam logic [7:0] OFS_COUNT = 8'h08;
  localparam logic [7:0] OFS_STAT  = 8'h0C;
  localparam logic [7:0] OFS_GPIO  = 8'h10;
  localparam logic [7:0] OFS_CYCLE = 8'h14;

  localparam int CTRL_EN  = 0;
  localparam int CTRL_AR  = 1;
  localparam int CTRL_IRQ = 2;
  localparam int STAT_EXP = 0;

endpackage

// File: rtl/dmem_timer.sv
// Down-counting timer with optional auto-reload and a level interrupt.
// Holds CTRL, LOAD, COUNT and STAT; the parent supplies write strobes and data.
module dmem_timer
  import dmem_mmio_pkg::*;
#(
  parameter int TIMER_W = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        wr_ctrl,
  input  logic        wr_load,
  input  logic        wr_count,
  input  logic        wr_stat,
  input  logic [31:0] wdata,
  output logic [31:0] ctrl_rd,
  output logic [31:0] load_rd,
  output logic [31:0] count_rd,
  output logic [31:0] stat_rd,
  output logic        irq
);

  logic [2:0]         ctrl;
  logic [TIMER_W-1:0] load;
  logic [TIMER_W-1:0] count;
  logic               expired;
  logic               expire_now;
  logic               unused_wdata;

  // A COUNT write suppresses the tick entirely, including expiry.
  assign expire_now = ctrl[CTRL_EN] && (count == '0) && !wr_count;

  always_ff @(posedge clk) begin
    if (reset) begin
      ctrl    <= '0;
      load    <= '0;
      count   <= '0;
      expired <= 1'b0;
    end else begin
      if (wr_ctrl)
        ctrl <= wdata[2:0];
      else if (expire_now && !ctrl[CTRL_AR])
        ctrl[CTRL_EN] <= 1'b0;

      if (wr_load)
        load <= TIMER_W'(wdata);

      if (wr_count)
        count <= TIMER_W'(wdata);
      else if (ctrl[CTRL_EN] && count != '0)
        count <= count - TIMER_W'(1);
      else if (expire_now && ctrl[CTRL_AR])
        count <= load;

      // A new expiry beats a same-cycle write-1-to-clear.
      if (expire_now)
        expired <= 1'b1;
      else if (wr_stat && wdata[STAT_EXP])
        expired <= 1'b0;
    end
  end

  assign ctrl_rd      = {29'b0, ctrl};
  assign load_rd      = 32'(load);
  assign count_rd     = 32'(count);
  assign stat_rd      = {31'b0, expired};
  assign irq          = expired & ctrl[CTRL_IRQ];
  assign unused_wdata = ^wdata;

endmodule

// File: rtl/dmem_mmio.sv
// Data-side memory stage: word RAM plus an MMIO window (timer, GPIO, optional cycle counter).
// Optional cycle counter at offset 0x14 is built when DMEM_MMIO_CYCLE_CNT_EN is defined.
module dmem_mmio
  import dmem_mmio_pkg::*;
#(
  parameter int          RAM_AW  = 10,
  parameter logic [15:0] MMIO_HI = MMIO_HI_DEFAULT,
  parameter int          TIMER_W = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] maddr,
  input  logic [31:0] mwdata,
  input  logic        DM_CS,
  input  logic        DM_R,
  input  logic        DM_W,
  output logic [31:0] mrdata,
  output logic [31:0] gpio_out,
  output logic        timer_irq
);

  logic [31:0]       ram [2**RAM_AW];
  logic              mmio_sel;
  logic              wr_en;
  logic              wr_mmio;
  logic [7:0]        ofs;
  logic [RAM_AW-1:0] ram_idx;
  logic [31:0]       gpio;
  logic [31:0]       cycle_rd;
  logic [31:0]       ctrl_rd, load_rd, count_rd, stat_rd;
  logic              unused_addr;

  assign mmio_sel    = (maddr[31:16] == MMIO_HI);
  assign ofs         = maddr[7:0];
  assign ram_idx     = maddr[RAM_AW+1:2];
  assign wr_en       = DM_CS & DM_W;
  assign wr_mmio     = wr_en & mmio_sel;
  assign unused_addr = ^maddr;

  // No reset on the array; asynchronous read gives old data on a same-word write.
  always_ff @(posedge clk) begin
    if (wr_en && !mmio_sel)
      ram[ram_idx] <= mwdata;
  end

  always_ff @(posedge clk) begin
    if (reset)
      gpio <= '0;
    else if (wr_mmio && ofs == OFS_GPIO)
      gpio <= mwdata;
  end

`ifdef DMEM_MMIO_CYCLE_CNT_EN
  logic [31:0] cycle;

  always_ff @(posedge clk) begin
    if (reset)
      cycle <= '0;
    else
      cycle <= cycle + 32'd1;
  end

  assign cycle_rd = cycle;
`else
  assign cycle_rd = '0;
`endif

  dmem_timer #(.TIMER_W(TIMER_W)) u_timer (
    .clk      (clk),
    .reset    (reset),
    .wr_ctrl  (wr_mmio && ofs == OFS_CTRL),
    .wr_load  (wr_mmio && ofs == OFS_LOAD),
    .wr_count (wr_mmio && ofs == OFS_COUNT),
    .wr_stat  (wr_mmio && ofs == OFS_STAT),
    .wdata    (mwdata),
    .ctrl_rd  (ctrl_rd),
    .load_rd  (load_rd),
    .count_rd (count_rd),
    .stat_rd  (stat_rd),
    .irq      (timer_irq)
  );

  always_comb begin
    mrdata = '0;
    if (DM_CS && DM_R) begin
      if (mmio_sel) begin
        case (ofs)
          OFS_CTRL:  mrdata = ctrl_rd;
          OFS_LOAD:  mrdata = load_rd;
          OFS_COUNT: mrdata = count_rd;
          OFS_STAT:  mrdata = stat_rd;
          OFS_GPIO:  mrdata = gpio;
          OFS_CYCLE: mrdata = cycle_rd;
          default:   mrdata = '0;
        endcase
      end else begin
        mrdata = ram[ram_idx];
      end
    end
  end

  assign gpio_out = gpio;

endmodule

// File: tb/tb_dmem_mmio.sv
// Self-checking bench for dmem_mmio: vector table, directed timer sequences, random ops vs a reference model.
module tb_dmem_mmio;

  localparam int RAM_AW = 10;
`ifdef DMEM_MMIO_CYCLE_CNT_EN
  localparam bit CYC_EN = 1'b1;
`else
  localparam bit CYC_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] maddr = '0;
  logic [31:0] mwdata = '0;
  logic        DM_CS = 1'b0;
  logic        DM_R = 1'b0;
  logic        DM_W = 1'b0;
  logic [31:0] mrdata;
  logic [31:0] gpio_out;
  logic        timer_irq;

  dmem_mmio #(.RAM_AW(RAM_AW)) dut (
    .clk       (clk),
    .reset     (reset),
    .maddr     (maddr),
    .mwdata    (mwdata),
    .DM_CS     (DM_CS),
    .DM_R      (DM_R),
    .DM_W      (DM_W),
    .mrdata    (mrdata),
    .gpio_out  (gpio_out),
    .timer_irq (timer_irq)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail = 0;

  // Reference model state, expressed as plain register values.
  logic [31:0] m_ram [2**RAM_AW];
  bit          m_valid [2**RAM_AW];
  logic [2:0]  m_ctrl;
  logic [31:0] m_load, m_count, m_gpio, m_cycle;
  bit          m_exp;

  typedef struct {
    bit          cs;
    bit          r;
    bit          w;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp;
    bit          chk;
    string       name;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] model_read(input bit cs, input bit r, input logic [31:0] a,
                                             output bit known);
    known = 1'b1;
    if (!(cs && r)) return 32'h0;
    if (a[31:16] == 16'hFFFF) begin
      case (a[7:0])
        8'h00:   return {29'b0, m_ctrl};
        8'h04:   return m_load;
        8'h08:   return m_count;
        8'h0C:   return {31'b0, m_exp};
        8'h10:   return m_gpio;
        8'h14:   return CYC_EN ? m_cycle : 32'h0;
        default: return 32'h0;
      endcase
    end
    known = m_valid[a[RAM_AW+1:2]];
    return m_ram[a[RAM_AW+1:2]];
  endfunction

  task automatic model_step(input bit rst, input bit cs, input bit w, input logic [31:0] a,
                            input logic [31:0] d);
    bit          wr, mm, expire;
    logic [7:0]  ofs;
    logic [2:0]  nctrl;
    logic [31:0] ncount;
    if (rst) begin
      m_ctrl = '0; m_load = '0; m_count = '0; m_exp = 1'b0; m_gpio = '0; m_cycle = '0;
      return;
    end
    wr  = cs && w;
    mm  = (a[31:16] == 16'hFFFF);
    ofs = a[7:0];
    m_cycle = m_cycle + 32'd1;
    if (wr && !mm) begin
      m_ram[a[RAM_AW+1:2]]   = d;
      m_valid[a[RAM_AW+1:2]] = 1'b1;
    end
    expire = 1'b0;
    nctrl  = m_ctrl;
    ncount = m_count;
    if (wr && mm && ofs == 8'h08) ncount = d;
    else if (m_ctrl[0] && m_count != 0) ncount = m_count - 32'd1;
    else if (m_ctrl[0]) begin
      expire = 1'b1;
      if (m_ctrl[1]) ncount = m_load;
      else nctrl[0] = 1'b0;
    end
    if (wr && mm && ofs == 8'h00) nctrl = d[2:0];
    if (wr && mm && ofs == 8'h04) m_load = d;
    if (wr && mm && ofs == 8'h10) m_gpio = d;
    if (expire) m_exp = 1'b1;
    else if (wr && mm && ofs == 8'h0C && d[0]) m_exp = 1'b0;
    m_ctrl  = nctrl;
    m_count = ncount;
  endtask

  // One bus cycle: drive, sample the combinational read, clock, check outputs.
  task automatic do_op(input string name, input bit cs, input bit r, input bit w,
                       input logic [31:0] a, input logic [31:0] d,
                       input bit has_exp, input logic [31:0] exp, output logic [31:0] got);
    logic [31:0] mv;
    bit          known;
    DM_CS = cs; DM_R = r; DM_W = w; maddr = a; mwdata = d;
    #1;
    got = mrdata;
    mv  = model_read(cs, r, a, known);
    if (has_exp) chk({name, " const"}, got, exp);
    if (known)   chk({name, " model"}, got, mv);
    @(posedge clk);
    model_step(1'b0, cs, w, a, d);
    #1;
    chk({name, " gpio"}, gpio_out, m_gpio);
    chk({name, " irq"}, {31'b0, timer_irq}, {31'b0, m_exp & m_ctrl[2]});
    DM_CS = 1'b0; DM_R = 1'b0; DM_W = 1'b0;
  endtask

  task automatic wr(input string name, input logic [31:0] a, input logic [31:0] d);
    logic [31:0] g;
    do_op(name, 1'b1, 1'b0, 1'b1, a, d, 1'b0, 32'h0, g);
  endtask

  task automatic rd(input string name, input logic [31:0] a, input logic [31:0] exp);
    logic [31:0] g;
    do_op(name, 1'b1, 1'b1, 1'b0, a, 32'h0, 1'b1, exp, g);
  endtask

  task automatic idle();
    logic [31:0] g;
    do_op("idle", 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0, g);
  endtask

  // Reset is held for one edge together with a GPIO write that must lose.
  task automatic do_reset();
    reset = 1'b1;
    DM_CS = 1'b1; DM_W = 1'b1; DM_R = 1'b0; maddr = 32'hFFFF_0010; mwdata = 32'hFFFF_FFFF;
    @(posedge clk);
    model_step(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
    #1;
    reset = 1'b0;
    DM_CS = 1'b0; DM_W = 1'b0;
    chk("reset gpio_out", gpio_out, 32'h0);
    chk("reset irq", {31'b0, timer_irq}, 32'h0);
  endtask

  localparam logic [31:0] A_CTRL  = 32'hFFFF_0000;
  localparam logic [31:0] A_LOAD  = 32'hFFFF_0004;
  localparam logic [31:0] A_COUNT = 32'hFFFF_0008;
  localparam logic [31:0] A_STAT  = 32'hFFFF_000C;
  localparam logic [31:0] A_GPIO  = 32'hFFFF_0010;
  localparam logic [31:0] A_CYCLE = 32'hFFFF_0014;

  initial begin
    logic [31:0] g, c1, c2, a, d;
    bit          cs, r, w;
    logic [7:0]  ofs;

    for (int i = 0; i < 2**RAM_AW; i++) begin
      m_valid[i] = 1'b0;
      m_ram[i]   = '0;
    end
    model_step(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);

    vecs.push_back('{1, 0, 1, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0, 1, "ram_wr"});
    vecs.push_back('{1, 1, 0, 32'h0000_0010, 32'h0, 32'hDEAD_BEEF, 1, "ram_rd"});
    vecs.push_back('{1, 1, 0, 32'h0000_1010, 32'h0, 32'hDEAD_BEEF, 1, "ram_alias"});
    vecs.push_back('{1, 0, 0, 32'h0000_0010, 32'h0, 32'h0, 1, "ram_no_r"});
    vecs.push_back('{0, 1, 0, 32'h0000_0010, 32'h0, 32'h0, 1, "ram_no_cs"});
    vecs.push_back('{1, 0, 1, A_GPIO, 32'hA5A5_A5A5, 32'h0, 1, "gpio_wr"});
    vecs.push_back('{1, 1, 0, A_GPIO, 32'h0, 32'hA5A5_A5A5, 1, "gpio_rd"});
    vecs.push_back('{1, 0, 1, A_LOAD, 32'h1234_5678, 32'h0, 1, "load_wr"});
    vecs.push_back('{1, 1, 0, A_LOAD, 32'h0, 32'h1234_5678, 1, "load_rd"});
    vecs.push_back('{1, 0, 1, A_CTRL, 32'hFFFF_FFF2, 32'h0, 1, "ctrl_wr"});
    vecs.push_back('{1, 1, 0, A_CTRL, 32'h0, 32'h2, 1, "ctrl_rd"});
    vecs.push_back('{1, 0, 1, A_CYCLE, 32'h0001_2345, 32'h0, 1, "cyc_wr"});
    vecs.push_back('{1, 0, 1, 32'hFFFF_0020, 32'hFFFF_FFFF, 32'h0, 1, "unmap_wr"});
    vecs.push_back('{1, 1, 0, 32'hFFFF_0020, 32'h0, 32'h0, 1, "unmap_rd"});
    vecs.push_back('{1, 1, 0, A_CYCLE, 32'h0, 32'h0, !CYC_EN, "cyc_rd"});
    vecs.push_back('{1, 1, 0, A_GPIO, 32'h0, 32'hA5A5_A5A5, 1, "gpio_keep"});
    vecs.push_back('{1, 1, 0, A_STAT, 32'h0, 32'h0, 1, "stat_rd"});
    vecs.push_back('{1, 0, 1, A_CTRL, 32'h0, 32'h0, 1, "ctrl_clr"});

    do_reset();
    foreach (vecs[i])
      do_op(vecs[i].name, vecs[i].cs, vecs[i].r, vecs[i].w, vecs[i].addr, vecs[i].wdata,
            vecs[i].chk, vecs[i].exp, g);

    // One-shot timer
    do_reset();
    wr("os load", A_LOAD, 32'd3);
    wr("os count", A_COUNT, 32'd3);
    wr("os ctrl", A_CTRL, 32'd5);
    idle();
    rd("os count2", A_COUNT, 32'd2);
    rd("os count1", A_COUNT, 32'd1);
    chk("os irq low", {31'b0, timer_irq}, 32'h0);
    rd("os count0", A_COUNT, 32'd0);
    chk("os irq high", {31'b0, timer_irq}, 32'h1);
    rd("os stat", A_STAT, 32'h1);
    rd("os ctrl en clr", A_CTRL, 32'h4);
    idle();
    rd("os count hold", A_COUNT, 32'd0);

    // Auto-reload, W1C, and W1C coincident with expiry
    do_reset();
    wr("ar load", A_LOAD, 32'd2);
    wr("ar count", A_COUNT, 32'd0);
    wr("ar ctrl", A_CTRL, 32'd7);
    idle();
    chk("ar irq first", {31'b0, timer_irq}, 32'h1);
    rd("ar stat1", A_STAT, 32'h1);
    wr("ar w1c", A_STAT, 32'h1);
    chk("ar irq dropped", {31'b0, timer_irq}, 32'h0);
    rd("ar stat0", A_STAT, 32'h0);
    rd("ar count2", A_COUNT, 32'd2);
    rd("ar count1", A_COUNT, 32'd1);
    wr("ar w1c coinc", A_STAT, 32'h1);
    rd("ar stat stays", A_STAT, 32'h1);
    chk("ar irq stays", {31'b0, timer_irq}, 32'h1);

    // COUNT write beats decrement
    do_reset();
    wr("cf count50", A_COUNT, 32'd50);
    wr("cf ctrl", A_CTRL, 32'd1);
    wr("cf count100", A_COUNT, 32'd100);
    rd("cf read100", A_COUNT, 32'd100);
    rd("cf read99", A_COUNT, 32'd99);
    wr("cf stop", A_CTRL, 32'd0);

    // Reset in the middle of a running timer
    wr("rm ram", 32'h0000_0040, 32'h1234_5678);
    wr("rm gpio", A_GPIO, 32'hA5A5_A5A5);
    wr("rm load", A_LOAD, 32'd10);
    wr("rm count", A_COUNT, 32'd2);
    wr("rm ctrl", A_CTRL, 32'd7);
    for (int i = 0; i < 5; i++) idle();
    do_reset();
    rd("rm ctrl0", A_CTRL, 32'h0);
    rd("rm load0", A_LOAD, 32'h0);
    rd("rm count0", A_COUNT, 32'h0);
    rd("rm stat0", A_STAT, 32'h0);
    rd("rm gpio0", A_GPIO, 32'h0);
    rd("rm ram kept", 32'h0000_0040, 32'h1234_5678);

    // Cycle counter
    do_op("cyc n", 1'b1, 1'b1, 1'b0, A_CYCLE, 32'h0, !CYC_EN, 32'h0, c1);
    for (int i = 0; i < 4; i++) idle();
    do_op("cyc n5", 1'b1, 1'b1, 1'b0, A_CYCLE, 32'h0, !CYC_EN, 32'h0, c2);
    chk("cyc delta", c2 - c1, CYC_EN ? 32'd5 : 32'd0);

    // Random traffic against the reference model
    for (int i = 0; i < 3000; i++) begin
      cs = ($urandom_range(0, 9) != 0);
      r  = $urandom_range(0, 1) == 1;
      w  = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 1) == 1) begin
        a = $urandom;
        if (a[31:16] == 16'hFFFF) a[31:16] = 16'h0;
        a[11:2] = 10'($urandom_range(0, 15));
        d = $urandom;
      end else begin
        ofs = 8'(4 * $urandom_range(0, 9));
        a   = {16'hFFFF, 8'($urandom), ofs};
        d   = (ofs == 8'h04 || ofs == 8'h08) ? 32'($urandom_range(0, 5)) : $urandom;
      end
      do_op("rand", cs, r, w, a, d, 1'b0, 32'h0, g);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
